// File: rtl/alu_exec_unit.sv
// ALU execution unit: takes a control code and two operands over valid/ready,
// computes the result and holds it with its flags in a single-entry output buffer.
module alu_exec_unit #(
    parameter int WIDTH = 64,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             err,
    output logic [ERRW-1:0]  err_count
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t state, next_state;

    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] calc_result;
    logic             calc_ovf;
    logic             calc_err;

    assign res_valid = (state == FULL);
    assign op_ready  = !res_valid || res_ready;
    assign accept    = op_valid && op_ready;

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    always_comb begin
        calc_result = '0;
        calc_ovf    = 1'b0;
        calc_err    = 1'b0;
        case (ctrl)
            4'b0010: begin
                calc_result = sum;
                calc_ovf    = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'b0110: begin
                calc_result = diff;
                calc_ovf    = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'b0011: calc_result = src_a & src_b;
            4'b0100: calc_result = src_a | src_b;
            4'b0101: calc_result = src_a ^ src_b;
            4'b0111: calc_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0000: calc_result = '0;
            default: calc_err    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // A consume with a simultaneous accept keeps the buffer full.
    always_comb begin
        next_state = state;
        case (state)
            EMPTY: if (accept) next_state = FULL;
            FULL:  if (res_ready && !op_valid) next_state = EMPTY;
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else if (accept) begin
            result <= calc_result;
            zero   <= (calc_result == '0);
            ovf    <= calc_ovf;
            err    <= calc_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (accept && calc_err && (err_count != '1)) begin
            err_count <= err_count + ERRW'(1);
        end
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder. Accepts an operation (control code plus two operands) over a valid/ready handshake, computes it, and holds the registered result, flags and error status in a single-entry output buffer until the downstream stage takes it. It sits between the decode/control stage and the writeback stage of the datapath.

## Interface
- WIDTH, 64, operand and result width in bits (≥ 2)
- ERRW, 8, width of the illegal-operation counter

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  operation present on ctrl/src_a/src_b
- op_ready  out  1  unit accepts the operation this cycle
- ctrl  in  4  ALU control code from the control decoder
- src_a  in  WIDTH  operand A
- src_b  in  WIDTH  operand B
- res_valid  out  1  result buffer holds a result
- res_ready  in  1  downstream takes the result this cycle
- result  out  WIDTH  computed value
- zero  out  1  result == 0
- ovf  out  1  signed overflow (ADD/SUB only, else 0)
- err  out  1  the held result came from an illegal code
- err_count  out  ERRW  saturating count of accepted illegal codes

## Operation
- Accept when op_valid && op_ready. Store the computed result, zero, ovf and err into the output buffer in the same edge, and set res_valid.
- op_ready = !res_valid || res_ready. This is combinational and gives full throughput with one op per cycle.
- Control code map (all arithmetic is modulo 2^WIDTH):
  - 4'b0010 ADD: a+b. ovf = operands have the same sign and the result sign differs.
  - 4'b0110 SUB: a−b. ovf = operands have different signs and the result sign differs from a.
  - 4'b0011 AND, 4'b0100 OR, 4'b0101 XOR: bitwise.
  - 4'b0111 SLT: result = {0…, $signed(a) < $signed(b)}.
  - 4'b0000 NOP: result = 0, err = 0.
  - 4'b1111 and every other code are illegal: result = 0, err = 1, ovf = 0. err_count increments and saturates at all-ones.
- zero is computed from the stored result, so it is 1 for NOP and illegal codes.
- Buffer state machine:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on res_ready && !op_valid.
  - FULL → FULL on res_ready && op_valid. The old result is consumed and the new one is loaded in the same edge.
  - FULL with !res_ready: the buffer holds; op_ready = 0 and inputs are ignored.
- Buffer outputs never change while res_valid && !res_ready.

## Timing
- Reset (rst_n low, asynchronous) clears every output register:
  - res_valid = 0, result = 0, zero = 0, ovf = 0, err = 0, err_count = 0.
  - op_ready = 1 while in reset.
- Latency: an op accepted at edge N shows res_valid = 1 with its result after edge N. It is visible in cycle N+1.
- Throughput: 1 op/cycle with res_ready held high.
- Reset asserted mid-transfer discards the held result. There is no partial update on the deasserting edge.
- err_count at saturation stays at all-ones on further illegal accepts.
- Simultaneous consume and accept: the new result replaces the old one with no bubble. err_count counts only the new op.

## Test plan
- Reset then idle → res_valid = 0, op_ready = 1, err_count = 0. Assert rst_n low while res_valid = 1 → res_valid drops immediately, without waiting for a clock edge.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → result = 0x8000_0000_0000_0000, ovf = 1, zero = 0. SUB 5 − 5 → result 0, zero = 1, ovf = 0.
- AND/OR/XOR with a = 0xF0F0, b = 0xFF00 → 0xF000, 0xFFF0, 0x0FF0. SLT a = −1, b = 1 → result 1. SLT a = 1, b = −1 → result 0.
- ctrl = 4'b1111, then 4'b1001 → err = 1 and result = 0 on both, err_count = 2. ctrl = 4'b0000 → err = 0, zero = 1.
- Back-pressure: hold res_ready = 0 with op_valid = 1 for 3 cycles → op_ready = 0, result held stable. Then res_ready = 1 for one cycle → the old result is consumed and the pending op loads on the same edge.
- Streaming: 10 consecutive ADDs with res_ready = 1 → 10 results on consecutive cycles in order, no bubbles. Drive 2^ERRW + 3 illegal codes → err_count = all-ones.
